// File: rtl/maze_solver_if.sv
// maze_solver_if
//   Bundles the request and walk-report signals of the maze solver.
//   master (requester / player logic):
//     out start, maze_data[255:0], start_x/start_y, goal_x/goal_y
//     in  curr_x/curr_y, step_valid, step_count[9:0], busy, done, found
//   slave (maze_solver): the same signals with directions reversed.
interface maze_solver_if;
  logic         start;
  logic [255:0] maze_data;
  logic [3:0]   start_x;
  logic [3:0]   start_y;
  logic [3:0]   goal_x;
  logic [3:0]   goal_y;
  logic [3:0]   curr_x;
  logic [3:0]   curr_y;
  logic         step_valid;
  logic [9:0]   step_count;
  logic         busy;
  logic         done;
  logic         found;

  modport master (
    output start, maze_data, start_x, start_y, goal_x, goal_y,
    input  curr_x, curr_y, step_valid, step_count, busy, done, found
  );

  modport slave (
    input  start, maze_data, start_x, start_y, goal_x, goal_y,
    output curr_x, curr_y, step_valid, step_count, busy, done, found
  );
endinterface

// File: rtl/maze_solver.sv
// maze_solver
//   Right-hand wall follower over a 16x16 bitmap (bit x+16*y = 1 is open).
//   On start the bitmap, start and goal cells are snapshotted; the walker
//   then moves one cell per clock, trying right-turn, straight, left-turn
//   and back in that order, until it reaches the goal, hits the step cap,
//   or finds itself on a closed or isolated cell.
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    maze_solver_if.slave: request inputs and walk-report outputs
// Parameters
//   MAX_STEPS  step cap, 1..1023
module maze_solver #(
  parameter int unsigned MAX_STEPS = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  maze_solver_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] HEAD_UP    = 2'd0;
  localparam logic [1:0] HEAD_RIGHT = 2'd1;
  localparam logic [1:0] HEAD_DOWN  = 2'd2;
  localparam logic [1:0] HEAD_LEFT  = 2'd3;
  localparam logic [9:0] STEP_CAP   = 10'(MAX_STEPS);

  state_t       state, state_next;
  logic [255:0] snap, snap_next;
  logic [3:0]   goal_x, goal_x_next, goal_y, goal_y_next;
  logic [3:0]   curr_x, curr_x_next, curr_y, curr_y_next;
  logic [1:0]   heading, heading_next;
  logic [9:0]   step_count, step_count_next;
  logic         step_valid, step_valid_next;
  logic         found, found_next;

  logic         move_ok;
  logic [1:0]   move_dir;
  logic [3:0]   move_x, move_y;
  logic [1:0]   cand_dir;
  logic [8:0]   cand_res;

  // Returns {open, ny, nx} for the neighbour of (x,y) in direction dir.
  // Out-of-range neighbours are reported closed, so there is no wrap-around.
  function automatic logic [8:0] probe(input logic [1:0] dir, input logic [3:0] x,
                                       input logic [3:0] y, input logic [255:0] map);
    logic       in_bounds;
    logic [3:0] nx, ny;
    in_bounds = 1'b0;
    nx = x;
    ny = y;
    case (dir)
      HEAD_UP:    begin in_bounds = (y != 4'd0);  ny = y - 4'd1; end
      HEAD_RIGHT: begin in_bounds = (x != 4'd15); nx = x + 4'd1; end
      HEAD_DOWN:  begin in_bounds = (y != 4'd15); ny = y + 4'd1; end
      HEAD_LEFT:  begin in_bounds = (x != 4'd0);  nx = x - 4'd1; end
    endcase
    return {in_bounds && map[{ny, nx}], ny, nx};
  endfunction

  // Candidate i (0..3) is heading + (i ^ 1): +1 right, +0 straight,
  // +3 left, +2 back. Scanning from the lowest priority upward lets the
  // highest-priority open candidate overwrite the rest.
  always_comb begin
    move_ok  = 1'b0;
    move_dir = heading;
    move_x   = curr_x;
    move_y   = curr_y;
    cand_dir = heading;
    cand_res = '0;
    for (int i = 3; i >= 0; i--) begin
      cand_dir = heading + (2'(i) ^ 2'b01);
      cand_res = probe(cand_dir, curr_x, curr_y, snap);
      if (cand_res[8]) begin
        move_ok  = 1'b1;
        move_dir = cand_dir;
        move_x   = cand_res[3:0];
        move_y   = cand_res[7:4];
      end
    end
  end

  always_comb begin
    state_next      = state;
    snap_next       = snap;
    goal_x_next     = goal_x;
    goal_y_next     = goal_y;
    curr_x_next     = curr_x;
    curr_y_next     = curr_y;
    heading_next    = heading;
    step_count_next = step_count;
    step_valid_next = 1'b0;
    found_next      = found;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next      = RUN;
          snap_next       = bus.maze_data;
          goal_x_next     = bus.goal_x;
          goal_y_next     = bus.goal_y;
          curr_x_next     = bus.start_x;
          curr_y_next     = bus.start_y;
          heading_next    = HEAD_RIGHT;
          step_count_next = '0;
          found_next      = 1'b0;
        end
      end
      RUN: begin
        // The walker only ever enters open cells, so a closed current cell
        // can only be seen on the first RUN cycle (a closed start cell).
        if (!snap[{curr_y, curr_x}]) begin
          state_next = DONE;
          found_next = 1'b0;
        end else if (curr_x == goal_x && curr_y == goal_y) begin
          state_next = DONE;
          found_next = 1'b1;
        end else if (step_count == STEP_CAP) begin
          state_next = DONE;
          found_next = 1'b0;
        end else if (move_ok) begin
          curr_x_next     = move_x;
          curr_y_next     = move_y;
          heading_next    = move_dir;
          step_count_next = step_count + 10'd1;
          step_valid_next = 1'b1;
        end else begin
          state_next = DONE;
          found_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      goal_x     <= '0;
      goal_y     <= '0;
      curr_x     <= '0;
      curr_y     <= '0;
      heading    <= HEAD_RIGHT;
      step_count <= '0;
      step_valid <= 1'b0;
      found      <= 1'b0;
    end else begin
      state      <= state_next;
      snap       <= snap_next;
      goal_x     <= goal_x_next;
      goal_y     <= goal_y_next;
      curr_x     <= curr_x_next;
      curr_y     <= curr_y_next;
      heading    <= heading_next;
      step_count <= step_count_next;
      step_valid <= step_valid_next;
      found      <= found_next;
    end
  end

  assign bus.curr_x     = curr_x;
  assign bus.curr_y     = curr_y;
  assign bus.step_valid = step_valid;
  assign bus.step_count = step_count;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.found      = found;

endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver
//   Directed scoreboard bench for maze_solver. Stimulus pushes expected
//   step positions and walk results into queues; a negedge monitor pops
//   and compares them whenever step_valid pulses or done rises.
module tb_maze_solver;

  typedef struct {
    int x;
    int y;
  } pos_t;

  typedef struct {
    int found;
    int steps;
    int ex;
    int ey;
    int edge_n;
  } res_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic done_prev;
  pos_t pos_q[$];
  res_t res_q[$];
  pos_t mon_p;
  res_t mon_r;

  maze_solver_if bus ();

  maze_solver #(.MAX_STEPS(1023)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the last rising edge when read at a negedge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNote(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got event, expected none/other (edge %0d)", name, cyc);
  endtask

  task automatic pushCorridor(input int n);
    for (int i = 1; i <= n; i++) pos_q.push_back('{i, 0});
  endtask

  // Starts a walk; returns the edge index N at which start was sampled.
  task automatic applyStimulus(input logic [255:0] m, input int sx, input int sy,
                               input int gx, input int gy, input int ef, input int ek,
                               input int ex, input int ey, input bit hold,
                               input bit push_res, output int n_edge);
    @(negedge clk);
    bus.maze_data = m;
    bus.start_x   = 4'(sx);
    bus.start_y   = 4'(sy);
    bus.goal_x    = 4'(gx);
    bus.goal_y    = 4'(gy);
    bus.start     = 1'b1;
    @(negedge clk);
    n_edge = cyc;
    if (!hold) bus.start = 1'b0;
    checkOutput("start_busy", bus.busy, 1);
    checkOutput("start_done", bus.done, 0);
    checkOutput("start_curr_x", bus.curr_x, sx);
    checkOutput("start_curr_y", bus.curr_y, sy);
    checkOutput("start_count", bus.step_count, 0);
    if (push_res) res_q.push_back('{ef, ek, ex, ey, n_edge + ek + 1});
  endtask

  task automatic waitDone(input int limit, input bit toggle);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (toggle) bus.maze_data = ~bus.maze_data;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) failNote("done_timeout");
  endtask

  // Monitor: compares each step and each walk result against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.step_valid) begin
        checkOutput("step_in_run", bus.busy, 1);
        if (pos_q.size() == 0) begin
          failNote("unexpected_step");
        end else begin
          mon_p = pos_q.pop_front();
          checkOutput("step_x", bus.curr_x, mon_p.x);
          checkOutput("step_y", bus.curr_y, mon_p.y);
        end
      end
      if (bus.done && !done_prev) begin
        checkOutput("done_no_valid", bus.step_valid, 0);
        checkOutput("done_not_busy", bus.busy, 0);
        if (res_q.size() == 0) begin
          failNote("unexpected_done");
        end else begin
          mon_r = res_q.pop_front();
          checkOutput("res_found", bus.found, mon_r.found);
          checkOutput("res_count", bus.step_count, mon_r.steps);
          checkOutput("res_x", bus.curr_x, mon_r.ex);
          checkOutput("res_y", bus.curr_y, mon_r.ey);
          checkOutput("res_edge", cyc, mon_r.edge_n);
        end
      end
    end
    done_prev <= bus.done;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] corr;
    logic [255:0] edge_m;
    logic [255:0] m;
    int n;
    int d;
    int x;
    int dir;

    n_checks = 0;
    n_fail   = 0;
    done_prev = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.maze_data = '0;
    bus.start_x = '0;
    bus.start_y = '0;
    bus.goal_x  = '0;
    bus.goal_y  = '0;

    corr = '0;
    for (int i = 0; i <= 5; i++) corr[i] = 1'b1;
    edge_m = '0;
    for (int i = 0; i < 16; i++) edge_m[i] = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_curr_x", bus.curr_x, 0);
    checkOutput("rst_curr_y", bus.curr_y, 0);
    checkOutput("rst_count", bus.step_count, 0);
    checkOutput("rst_valid", bus.step_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_found", bus.found, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Corridor
    $display("[TB] corridor");
    pushCorridor(5);
    applyStimulus(corr, 0, 0, 5, 0, 1, 5, 5, 0, 1'b0, 1'b1, n);
    waitDone(20, 1'b0);
    @(negedge clk);
    checkOutput("hold_done", bus.done, 1);
    checkOutput("hold_count", bus.step_count, 5);
    checkOutput("hold_valid", bus.step_valid, 0);

    // Edge, no wrap: bounces along row 0 until the step cap
    $display("[TB] edge no-wrap");
    x = 0;
    dir = 1;
    for (int k = 1; k <= 1023; k++) begin
      if (x == 15) dir = -1;
      if (x == 0) dir = 1;
      x = x + dir;
      pos_q.push_back('{x, 0});
    end
    applyStimulus(edge_m, 0, 0, 0, 1, 0, 1023, 3, 0, 1'b0, 1'b1, n);
    waitDone(1100, 1'b0);

    // Degenerate starts
    $display("[TB] degenerate starts");
    m = '0;
    m[3 + 16*3] = 1'b1;
    applyStimulus(m, 3, 3, 3, 3, 1, 0, 3, 3, 1'b0, 1'b1, n);
    waitDone(5, 1'b0);
    m = '1;
    m[2 + 16*2] = 1'b0;
    applyStimulus(m, 2, 2, 5, 5, 0, 0, 2, 2, 1'b0, 1'b1, n);
    waitDone(5, 1'b0);

    // Turn priority
    $display("[TB] turn priority");
    m = '0;
    m[0] = 1'b1;
    m[1] = 1'b1;
    m[2] = 1'b1;
    m[1 + 16] = 1'b1;
    m[2 + 16] = 1'b1;
    pos_q.push_back('{1, 0});
    pos_q.push_back('{1, 1});
    pos_q.push_back('{2, 1});
    pos_q.push_back('{2, 0});
    applyStimulus(m, 0, 0, 2, 0, 1, 4, 2, 0, 1'b0, 1'b1, n);
    waitDone(10, 1'b0);

    // Snapshot: bitmap toggled every cycle during the walk
    $display("[TB] snapshot");
    pushCorridor(5);
    applyStimulus(corr, 0, 0, 5, 0, 1, 5, 5, 0, 1'b0, 1'b1, n);
    waitDone(20, 1'b1);

    // Restart with start held through DONE
    $display("[TB] restart");
    pushCorridor(5);
    pushCorridor(5);
    applyStimulus(corr, 0, 0, 5, 0, 1, 5, 5, 0, 1'b1, 1'b1, n);
    waitDone(20, 1'b0);
    d = cyc;
    res_q.push_back('{1, 5, 5, 0, d + 1 + 6});
    @(negedge clk);
    checkOutput("restart_busy", bus.busy, 1);
    checkOutput("restart_curr_x", bus.curr_x, 0);
    checkOutput("restart_count", bus.step_count, 0);
    bus.start = 1'b0;
    waitDone(20, 1'b0);

    // Reset mid-RUN after 3 steps
    $display("[TB] reset mid-run");
    pushCorridor(3);
    applyStimulus(corr, 0, 0, 5, 0, 1, 5, 5, 0, 1'b0, 1'b0, n);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_curr_x", bus.curr_x, 0);
    checkOutput("arst_curr_y", bus.curr_y, 0);
    checkOutput("arst_count", bus.step_count, 0);
    checkOutput("arst_valid", bus.step_valid, 0);
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_done", bus.done, 0);
    checkOutput("arst_found", bus.found, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_busy", bus.busy, 0);
    checkOutput("post_rst_done", bus.done, 0);
    pushCorridor(5);
    applyStimulus(corr, 0, 0, 5, 0, 1, 5, 5, 0, 1'b0, 1'b1, n);
    waitDone(20, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("pos_q_empty", pos_q.size(), 0);
    checkOutput("res_q_empty", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
